// File: rtl/score_pkg.sv
// score_pkg
// Shared definitions for the score recorder and the score loader:
// note code width, rest code, default score RAM geometry, count-in length,
// beat counter width and the recorder state encoding.
package score_pkg;

    localparam int NOTE_W         = 4;
    localparam logic [NOTE_W-1:0] NOTE_REST = 4'h0;
    localparam int SCORE_ADDR_W   = 7;
    localparam int SCORE_DEPTH    = 128;
    localparam int COUNT_IN_BEATS = 4;
    localparam int BEAT_CNT_W     = 26;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT_IN = 2'd1,
        ST_REC      = 2'd2,
        ST_DONE     = 2'd3
    } score_state_e;

endpackage

// File: rtl/beat_timer.sv
// beat_timer
// Beat counter shared by the score recorder and the score loader.
// Counts 0..TEMPO_COUNT-1 while run is high and flags the last cycle of
// each beat.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : force the count back to 0 (takes priority over run)
//   run        : advance the count this cycle
//   beat       : high on the last cycle of a beat window (only while run)
module beat_timer
    import score_pkg::*;
#(
    parameter int TEMPO_COUNT = 65_000_000,
    parameter int CNT_W       = BEAT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic beat
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TEMPO_COUNT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign beat = run && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = beat ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/musical_score_recorder.sv
// musical_score_recorder
// Captures pitch-detector notes while the player performs, quantises them
// to one note code per tempo beat and writes the codes sequentially into
// the score RAM.
// Build option: define SCORE_REC_COUNT_IN_EN to add a four-beat count-in
// (metronome ticks, no capture, no writes) before recording starts.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, stop         : one-cycle pulses to begin / end a recording
//   note_in, note_valid : detected note code (0 = rest) and its qualifier
//   wr_en/addr/data     : score RAM write port, one write per beat
//   beat_tick           : metronome pulse at every beat while busy
//   busy, done          : recording (or counting in) / finished
//   song_len            : number of notes written so far
module musical_score_recorder
    import score_pkg::*;
#(
    parameter int TEMPO_COUNT = 65_000_000,
    parameter int ADDR_W      = SCORE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [NOTE_W-1:0] note_in,
    input  logic              note_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [NOTE_W-1:0] wr_data,
    output logic              beat_tick,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   song_len
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    score_state_e      state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [NOTE_W-1:0] wr_data_q, wr_data_d;
    logic              beat_tick_q, beat_tick_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   song_len_q, song_len_d;
    logic [NOTE_W-1:0] capture_q, capture_d;
    logic [NOTE_W-1:0] note_now;
    logic              beat;
    logic              start_ok;
`ifdef SCORE_REC_COUNT_IN_EN
    logic [1:0]        cin_q, cin_d;
`endif

    // A start is only accepted when not busy; it also restarts the beat grid.
    assign start_ok = start && !busy_q;

    beat_timer #(
        .TEMPO_COUNT (TEMPO_COUNT),
        .CNT_W       (BEAT_CNT_W)
    ) u_beat_timer (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .run   (busy_q),
        .beat  (beat)
    );

    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        beat_tick_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        song_len_d  = song_len_q;
        capture_d   = capture_q;
        // A note arriving on the beat cycle itself still belongs to this window.
        note_now    = note_valid ? note_in : capture_q;
`ifdef SCORE_REC_COUNT_IN_EN
        cin_d       = cin_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    wr_addr_d  = '0;
                    song_len_d = '0;
                    capture_d  = NOTE_REST;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
`ifdef SCORE_REC_COUNT_IN_EN
                    cin_d      = 2'd0;
                    state_d    = ST_COUNT_IN;
`else
                    state_d    = ST_REC;
`endif
                end
            end
`ifdef SCORE_REC_COUNT_IN_EN
            ST_COUNT_IN: begin
                beat_tick_d = beat;
                if (beat) begin
                    cin_d = cin_q + 2'd1;
                    if (cin_q == 2'(COUNT_IN_BEATS - 1)) begin
                        state_d = ST_REC;
                    end
                end
                if (stop) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            ST_REC: begin
                capture_d   = note_now;
                beat_tick_d = beat;
                if (beat) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = note_now;
                    wr_addr_d  = song_len_q[ADDR_W-1:0];
                    song_len_d = song_len_q + 1'b1;
                    capture_d  = NOTE_REST;
                    // Last address written: finish with no wrap.
                    if (song_len_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                // Stop drops the partial window; a coincident beat write still goes out.
                if (stop) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= NOTE_REST;
            beat_tick_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            song_len_q  <= '0;
            capture_q   <= NOTE_REST;
`ifdef SCORE_REC_COUNT_IN_EN
            cin_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            beat_tick_q <= beat_tick_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            song_len_q  <= song_len_d;
            capture_q   <= capture_d;
`ifdef SCORE_REC_COUNT_IN_EN
            cin_q       <= cin_d;
`endif
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign beat_tick = beat_tick_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign song_len  = song_len_q;

endmodule

// File: tb/tb_musical_score_recorder.sv
module tb_musical_score_recorder;

    localparam int T     = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
`ifdef SCORE_REC_COUNT_IN_EN
    localparam int CIN = 4;
`else
    localparam int CIN = 0;
`endif
    localparam int OFF = CIN * T;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [3:0]    note_in = 4'h0;
    logic          note_valid = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          beat_tick;
    logic          busy;
    logic          done;
    logic [AW:0]   song_len;

    musical_score_recorder #(.TEMPO_COUNT(T), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .note_in    (note_in),
        .note_valid (note_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .beat_tick  (beat_tick),
        .busy       (busy),
        .done       (done),
        .song_len   (song_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct { int c; int a; int d; } wr_t;
    wr_t sb_q[$];

    // Reference model: position since start and last note of the window.
    bit m_busy = 0, m_done = 0, m_tick = 0, m_wr = 0;
    int m_len = 0, m_pos = 0, m_last = 0;
    // Model values the DUT should be showing right now.
    bit e_busy = 0, e_done = 0, e_tick = 0, e_wr = 0;
    int e_len = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rs, input bit st, input bit sp, input bit nv, input logic [3:0] n);
        bit in_rec;
        @(posedge clk);
        #2;
        e_busy = m_busy; e_done = m_done; e_len = m_len; e_tick = m_tick; e_wr = m_wr;
        reset = rs; start = st; stop = sp; note_valid = nv; note_in = n;
        m_tick = 0; m_wr = 0;
        if (rs) begin
            m_busy = 0; m_done = 0; m_len = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_done = 0; m_len = 0; m_pos = 0; m_last = 0;
            end
        end else begin
            m_pos++;
            in_rec = ((m_pos - 1) / T) >= CIN;
            if (in_rec && nv) m_last = n;
            if (m_pos % T == 0) begin
                m_tick = 1;
                if (in_rec) begin
                    m_wr = 1;
                    sb_q.push_back('{cyc + 1, m_len % DEPTH, m_last});
                    m_len++;
                    m_last = 0;
                    if (m_len == DEPTH) begin
                        m_busy = 0; m_done = 1;
                    end
                end
            end
            if (sp && m_busy) begin
                m_busy = 0; m_done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0);
    endtask

    task automatic idle_rnd(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, ($urandom % 3) == 0, 4'($urandom_range(0, 15)));
    endtask

    // Monitor: per-cycle control outputs plus scoreboard pop on each write.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("song_len", song_len, e_len);
            chk("beat_tick", beat_tick, e_tick);
            chk("wr_en", wr_en, e_wr);
            if (wr_en) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: addr %0d data %0d with no write expected", wr_addr, wr_data);
                end else begin
                    wr_t w;
                    w = sb_q.pop_front();
                    chk("wr_addr", wr_addr, w.a);
                    chk("wr_data", wr_data, w.d);
                    chk("wr_cycle", cyc, w.c);
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 4'h0);
        chk_en = 1;
        step(1, 0, 0, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_song_len", song_len, 0);
        step(0, 0, 1, 0, 4'h0);           // stop while idle: ignored
        idle(2);
        chk("idle_stop_done", done, 0);

        // note 5 on cycle 2 of beat 0, nothing in beat 1
        step(0, 1, 0, 0, 4'h0);
        idle(OFF + 1);
        step(0, 0, 0, 1, 4'h5);
        idle(6);
        step(0, 0, 1, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);
        chk("t1_len", song_len, 2);
        idle(2);

        // 3 then 7 in one window, 9 on the beat cycle
        step(0, 1, 0, 0, 4'h0);
        idle(OFF);
        step(0, 0, 0, 1, 4'h3);
        step(0, 0, 0, 1, 4'h7);
        step(0, 0, 0, 0, 4'h0);
        step(0, 0, 0, 1, 4'h9);
        step(0, 0, 1, 1, 4'h2);
        step(0, 0, 0, 0, 4'h0);
        chk("t2_len", song_len, 1);
        idle(2);

        // record until full
        step(0, 1, 0, 0, 4'h0);
        idle_rnd(OFF + DEPTH * T + 6);
        chk("full_len", song_len, DEPTH);
        chk("full_done", done, 1);
        chk("full_busy", busy, 0);

        // stop mid-beat after two writes
        step(0, 1, 0, 0, 4'h0);
        idle_rnd(OFF + 9);
        step(0, 0, 1, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);
        chk("stop_mid_done", done, 1);
        chk("stop_mid_len", song_len, 2);
        idle(2);

        // stop on a beat cycle: that write still goes out
        step(0, 1, 0, 0, 4'h0);
        idle_rnd(OFF + 11);
        step(0, 0, 1, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);
        chk("stop_beat_wr", wr_en, 1);
        chk("stop_beat_len", song_len, 3);
        chk("stop_beat_done", done, 1);
        idle(2);

        // start while recording is ignored, then reset aborts
        step(0, 1, 0, 0, 4'h0);
        idle_rnd(OFF + 2);
        step(0, 1, 0, 1, 4'h6);
        idle_rnd(2 * T);
        step(1, 0, 0, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);
        chk("abort_busy", busy, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_len", song_len, 0);
        chk("abort_tick", beat_tick, 0);
        idle(T + 2);
        step(0, 1, 0, 0, 4'h0);
        idle_rnd(OFF + 2 * T + 1);
        step(0, 0, 1, 0, 4'h0);
        idle(2);

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            int len;
            len = $urandom_range(3, 45);
            step(0, 1, 0, 0, 4'h0);
            for (int i = 0; i < len; i++)
                step(0, ($urandom % 16) == 0, ($urandom % 30) == 0,
                     ($urandom % 3) == 0, 4'($urandom_range(0, 15)));
            step(0, 0, 1, 0, 4'h0);
            idle(3);
        end

        idle(4);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/musical_score_recorder.md
Name: musical_score_recorder

Overview:
- Writer side of the song-score ROM/RAM interface: captures notes from the pitch detector while the player performs.
- Quantises the notes to tempo beats, one 4-bit note code per beat.
- Writes the codes sequentially into a 128x4 score RAM, so a recorded song can later be replayed by the score loader.
- Sits between the pitch detector and the score RAM write port.

Parameters:
- TEMPO_COUNT, 65_000_000, clk cycles per beat (1 s at 65 MHz); legal range 2..2^26-1.
- ADDR_W, 7, score RAM address width; depth = 2^ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: begin a new recording
- stop  in  1  one-cycle pulse: end the recording
- note_in  in  4  detected note code; 0 = rest/none
- note_valid  in  1  note_in is a valid detection this cycle
- wr_en  out  1  score RAM write strobe, one cycle per beat
- wr_addr  out  ADDR_W  score RAM write address
- wr_data  out  4  score RAM write data
- beat_tick  out  1  one-cycle pulse at every beat boundary while busy (metronome)
- busy  out  1  recording, or counting in
- done  out  1  recording finished; held until next start or reset
- song_len  out  ADDR_W+1  number of notes written (0..2^ADDR_W)

Behaviour:
- Reset: state IDLE; wr_en=0, wr_addr=0, wr_data=0, beat_tick=0, busy=0, done=0, song_len=0; beat counter=0; capture register=0.
- Reset asserted mid-recording aborts immediately; no further writes occur.
- Beat counter: 26-bit, runs only while busy.
  - Counts 0..TEMPO_COUNT-1; beat = (count==TEMPO_COUNT-1); wraps to 0.
  - Cleared to 0 on start.
- States: IDLE, COUNT_IN (macro only), REC, DONE.
- IDLE/DONE + start:
  - clear wr_addr, song_len, capture and done;
  - go to REC (or COUNT_IN with the macro);
  - busy=1 from the next cycle.
- start while busy is ignored. stop in IDLE/DONE is ignored.
- Capture in REC:
  - Any cycle with note_valid=1 loads note_in into the capture register; the last valid note in the beat window wins.
  - A valid note on the beat cycle itself belongs to the closing beat.
- Beat in REC:
  - Registered outputs on the next cycle: wr_en=1, wr_data=captured note (0 if no valid note in the window), wr_addr=write pointer, beat_tick=1.
  - Pointer and song_len increment with the write.
  - Capture clears to 0 for the next window.
- Full:
  - The write to address 2^ADDR_W-1 sets song_len=2^ADDR_W.
  - State goes to DONE; busy drops and done rises in the same cycle as that final wr_en.
  - The pointer does not wrap and there is no write beyond depth.
- stop in REC:
  - The partial beat is discarded; go to DONE.
  - done=1 and busy=0 on the next cycle; song_len unchanged.
- stop and beat in the same cycle: the beat write is issued, then DONE.
- wr_en is never high outside a beat write. done and busy are never both 1.

Optional Feature:
- SCORE_REC_COUNT_IN_EN defined:
  - start enters COUNT_IN.
  - 4 beats elapse with beat_tick pulses and busy=1, but no writes and no capture.
  - On the 4th beat the state moves to REC and the beat counter continues without a gap.
  - stop during COUNT_IN goes to DONE with song_len=0.
- Not defined: COUNT_IN does not exist; start goes straight to REC.

Decomposition:
- Shared package score_pkg holds:
  - NOTE_W=4;
  - NOTE_REST=4'h0;
  - SCORE_ADDR_W=7;
  - SCORE_DEPTH=128;
  - COUNT_IN_BEATS=4;
  - the state enum encoding.
- One natural sub-module, beat_timer: parameterised beat counter with clear input and beat pulse output. The score loader shares it.

Test Plan:
- TEMPO_COUNT=4, start, note_valid with note_in=5 on cycle 2 of beat 0, nothing in beat 1 -> writes (addr0,5) then (addr1,0); beat_tick every 4 cycles.
- Notes 3 then 7 both inside one beat window, and a note 9 on that window's beat cycle -> single write data=9.
- Record until full, ADDR_W=3 -> 8 writes, addresses 0..7, song_len=8, done=1, no 9th wr_en.
- stop mid-beat after 2 writes -> song_len=2, done=1 the next cycle, partial beat not written. stop on a beat cycle -> that write still occurs (song_len=3).
- start while REC -> ignored, pointer unchanged. reset during REC -> all outputs at reset values next cycle; a following start records from addr 0.
- SCORE_REC_COUNT_IN_EN, TEMPO_COUNT=4 -> 4 beat_ticks with wr_en=0, then the first write at addr 0 on the 5th beat.
